// File: rtl/dma_to_sram_pkg.sv
// Shared definitions for the DMA-to-SRAM adapter: width helpers and the read response record.
package dma_to_sram_pkg;

    localparam int unsigned rsp_data_width_lp     = 64;
    localparam int unsigned default_strb_width_lp = rsp_data_width_lp / 32'd8;

    function automatic int unsigned idx_width(input int unsigned els);
        return (els > 32'd1) ? $clog2(els) : 32'd1;
    endfunction

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 32'd8;
    endfunction

    typedef struct packed {
        logic                         oor;
        logic [rsp_data_width_lp-1:0] data;
    } dma_rsp_t;

endpackage

// File: rtl/dma_to_sram_if.sv
// DMA request/response port plus the SRAM access port, seen from the adapter (slave) or its environment (master).
interface dma_to_sram_if
    import dma_to_sram_pkg::*;
#(
    parameter int unsigned addr_width_p = 64,
    parameter int unsigned data_width_p = 64,
    parameter int unsigned els_p        = 1024
);
    localparam int unsigned strb_width_lp     = strb_width(data_width_p);
    localparam int unsigned mem_addr_width_lp = idx_width(els_p);

    logic                         v_i;
    logic                         we_i;
    logic [addr_width_p-1:0]      addr_i;
    logic [strb_width_lp-1:0]     be_i;
    logic [data_width_p-1:0]      data_i;
    logic                         ready_o;
    logic                         v_o;
    logic [data_width_p-1:0]      data_o;
    logic                         ready_i;
    logic                         mem_v_o;
    logic                         mem_w_o;
    logic [mem_addr_width_lp-1:0] mem_addr_o;
    logic [strb_width_lp-1:0]     mem_wmask_o;
    logic [data_width_p-1:0]      mem_data_o;
    logic [data_width_p-1:0]      mem_data_i;

    modport slave (
        input  v_i, we_i, addr_i, be_i, data_i, ready_i, mem_data_i,
        output ready_o, v_o, data_o, mem_v_o, mem_w_o, mem_addr_o, mem_wmask_o, mem_data_o
    );

    modport master (
        output v_i, we_i, addr_i, be_i, data_i, ready_i, mem_data_i,
        input  ready_o, v_o, data_o, mem_v_o, mem_w_o, mem_addr_o, mem_wmask_o, mem_data_o
    );

endinterface

// File: rtl/dma_to_sram_rsp_fifo.sv
// Circular-buffer response FIFO (1r1w, valid/ready); a full FIFO still accepts when its head leaves that cycle.
module dma_rsp_fifo
    import dma_to_sram_pkg::*;
#(
    parameter int unsigned els_p   = 2,
    parameter int unsigned width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int unsigned ptr_width_lp   = idx_width(els_p);
    localparam int unsigned count_width_lp = $clog2(els_p + 32'd1);

    logic [width_p-1:0]        mem_r [els_p];
    logic [ptr_width_lp-1:0]   rd_ptr_r;
    logic [ptr_width_lp-1:0]   wr_ptr_r;
    logic [count_width_lp-1:0] count_r;
    logic                      enq_s;
    logic                      deq_s;

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] ptr);
        if (ptr == ptr_width_lp'(els_p - 32'd1)) begin
            return {ptr_width_lp{1'b0}};
        end else begin
            return ptr + ptr_width_lp'(1'b1);
        end
    endfunction

    assign v_o     = (count_r != {count_width_lp{1'b0}});
    assign ready_o = (count_r != count_width_lp'(els_p)) | yumi_i;
    assign deq_s   = v_o & yumi_i;
    assign enq_s   = v_i & ready_o;
    assign data_o  = mem_r[rd_ptr_r];

    // Pointer and occupancy state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= {ptr_width_lp{1'b0}};
            wr_ptr_r <= {ptr_width_lp{1'b0}};
            count_r  <= {count_width_lp{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (deq_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + count_width_lp'(1'b1);
                2'b01:   count_r <= count_r - count_width_lp'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides which entries are live
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/dma_to_sram.sv
// DMA request port to single-port SRAM (1-cycle read latency) with credit-limited, backpressured read responses.
module dma_to_sram
    import dma_to_sram_pkg::*;
#(
    parameter int unsigned             addr_width_p = 64,
    parameter int unsigned             data_width_p = 64,
    parameter int unsigned             els_p        = 1024,
    parameter logic [addr_width_p-1:0] base_addr_p  = {addr_width_p{1'b0}},
    parameter int unsigned             rsp_els_p    = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    dma_to_sram_if.slave bus
);
    localparam int unsigned strb_width_lp     = strb_width(data_width_p);
    localparam int unsigned offset_bits_lp    = $clog2(strb_width_lp);
    localparam int unsigned mem_addr_width_lp = idx_width(els_p);
    localparam int unsigned credit_width_lp   = $clog2(rsp_els_p + 32'd1);

    logic [addr_width_p-1:0]    offset_s;
    logic [addr_width_p-1:0]    idx_full_s;
    logic                       in_range_s;
    logic                       ready_s;
    logic                       accept_s;
    logic                       rd_accept_s;
    logic                       rd_pending_r;
    logic                       rd_oor_r;
    logic [credit_width_lp-1:0] credits_r;
    logic [data_width_p-1:0]    rsp_data_s;
    logic [data_width_p-1:0]    fifo_data_s;
    logic                       fifo_v_s;
    logic                       fifo_ready_s;
    logic                       fifo_enq_s;
    logic                       fifo_deq_s;
    logic                       bypass_s;
    logic                       rsp_fire_s;

    // Byte address to SRAM word index; offset bits below a word are ignored
    always_comb begin
        offset_s   = bus.addr_i - base_addr_p;
        idx_full_s = offset_s >> offset_bits_lp;
        in_range_s = (bus.addr_i >= base_addr_p) && (idx_full_s < addr_width_p'(els_p));
    end

    // Request acceptance and same-cycle SRAM access; ready never looks at v_i
    always_comb begin
        ready_s         = ~reset_i & (credits_r < credit_width_lp'(rsp_els_p));
        accept_s        = bus.v_i & ready_s;
        rd_accept_s     = accept_s & ~bus.we_i;
        bus.ready_o     = ready_s;
        bus.mem_v_o     = accept_s & in_range_s;
        bus.mem_w_o     = accept_s & in_range_s & bus.we_i;
        bus.mem_addr_o  = idx_full_s[mem_addr_width_lp-1:0];
        bus.mem_wmask_o = bus.be_i;
        bus.mem_data_o  = bus.data_i;
    end

    // Completing read bypasses the FIFO only when nothing older is waiting
    assign rsp_data_s = rd_oor_r ? {data_width_p{1'b0}} : bus.mem_data_i;
    assign bypass_s   = rd_pending_r & ~fifo_v_s & bus.ready_i;
    assign fifo_enq_s = rd_pending_r & ~bypass_s & fifo_ready_s;
    assign fifo_deq_s = fifo_v_s & bus.ready_i;
    assign rsp_fire_s = (fifo_v_s | rd_pending_r) & bus.ready_i;
    assign bus.v_o    = fifo_v_s | rd_pending_r;
    assign bus.data_o = fifo_v_s ? fifo_data_s : rsp_data_s;

    // Read in flight toward the SRAM and outstanding-response credits
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_pending_r <= 1'b0;
            rd_oor_r     <= 1'b0;
            credits_r    <= {credit_width_lp{1'b0}};
        end else begin
            rd_pending_r <= rd_accept_s;
            rd_oor_r     <= rd_accept_s & ~in_range_s;
            case ({rd_accept_s, rsp_fire_s})
                2'b10:   credits_r <= credits_r + credit_width_lp'(1'b1);
                2'b01:   credits_r <= credits_r - credit_width_lp'(1'b1);
                default: credits_r <= credits_r;
            endcase
        end
    end

    dma_rsp_fifo #(
        .els_p   (rsp_els_p),
        .width_p (data_width_p)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (fifo_enq_s),
        .data_i  (rsp_data_s),
        .ready_o (fifo_ready_s),
        .v_o     (fifo_v_s),
        .data_o  (fifo_data_s),
        .yumi_i  (fifo_deq_s)
    );

endmodule

// File: tb/tb_dma_to_sram.sv
// Bench for dma_to_sram: directed vector table, corner sequences and random traffic against a queue-based model.
module tb_dma_to_sram;
    import dma_to_sram_pkg::*;

    localparam int unsigned aw      = 64;
    localparam int unsigned dw      = 64;
    localparam int unsigned els     = 64;
    localparam int unsigned rsp_els = 2;
    localparam logic [63:0] base    = 64'h0000_0000_0000_1000;

    typedef logic [default_strb_width_lp-1:0] be_t;

    typedef struct {
        bit          v;
        bit          we;
        logic [63:0] addr;
        be_t         be;
        logic [63:0] data;
        bit          rdy;
        bit          e_ready;
        bit          e_memv;
        bit          e_memw;
        logic [63:0] e_maddr;
        bit          e_v;
        logic [63:0] e_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset_i = 1'b1;

    dma_to_sram_if #(.addr_width_p(aw), .data_width_p(dw), .els_p(els)) bus ();

    dma_to_sram #(
        .addr_width_p (aw),
        .data_width_p (dw),
        .els_p        (els),
        .base_addr_p  (base),
        .rsp_els_p    (rsp_els)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [dw-1:0] sram [els];
    logic [dw-1:0] sram_q;
    assign bus.mem_data_i = sram_q;

    always @(posedge clk) begin
        if (bus.mem_v_o) begin
            if (bus.mem_w_o) begin
                for (int b = 0; b < 8; b++) begin
                    if (bus.mem_wmask_o[b]) sram[bus.mem_addr_o][8*b +: 8] <= bus.mem_data_o[8*b +: 8];
                end
            end else begin
                sram_q <= sram[bus.mem_addr_o];
            end
        end
    end

    logic [dw-1:0] model_mem [els];
    dma_rsp_t      exp_q [$];
    vec_t          tbl [$];
    int            checks = 0;
    int            errors = 0;

    function automatic bit in_range(input logic [63:0] a);
        return (a >= base) && (((a - base) / 64'd8) < 64'(els));
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - base) / 64'd8);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit v, input bit we, input logic [63:0] addr,
                         input be_t be, input logic [63:0] data, input bit rdy);
        @(negedge clk);
        reset_i     = rst;
        bus.v_i     = v;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.be_i    = be;
        bus.data_i  = data;
        bus.ready_i = rdy;
        #1;
    endtask

    // Checks this cycle's outputs against the model, then advances the model across the clock edge.
    task automatic model_cycle();
        bit       exp_ready, exp_v, acc, inr;
        dma_rsp_t rsp;
        exp_ready = !reset_i && (exp_q.size() < rsp_els);
        exp_v     = exp_q.size() > 0;
        acc       = bus.v_i && exp_ready;
        inr       = in_range(bus.addr_i);
        chk("ready_o", bus.ready_o, exp_ready);
        chk("v_o", bus.v_o, exp_v);
        if (exp_v) chk("data_o", bus.data_o, exp_q[0].data);
        chk("mem_v_o", bus.mem_v_o, acc && inr);
        if (acc && inr) begin
            chk("mem_w_o", bus.mem_w_o, bus.we_i);
            chk("mem_addr_o", bus.mem_addr_o, 64'(widx(bus.addr_i)));
            if (bus.we_i) begin
                chk("mem_wmask_o", bus.mem_wmask_o, bus.be_i);
                chk("mem_data_o", bus.mem_data_o, bus.data_i);
            end
        end
        chk("fifo_overflow", dut.rd_pending_r & ~dut.bypass_s & ~dut.fifo_ready_s, 64'd0);
        if (reset_i) begin
            exp_q.delete();
        end else begin
            if (exp_v && bus.ready_i) void'(exp_q.pop_front());
            if (acc && bus.we_i && inr) begin
                for (int b = 0; b < 8; b++) begin
                    if (bus.be_i[b]) model_mem[widx(bus.addr_i)][8*b +: 8] = bus.data_i[8*b +: 8];
                end
            end
            if (acc && !bus.we_i) begin
                rsp.oor  = !inr;
                rsp.data = inr ? model_mem[widx(bus.addr_i)] : 64'h0;
                exp_q.push_back(rsp);
            end
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit we, input logic [63:0] addr,
                        input be_t be, input logic [63:0] data, input bit rdy);
        drive(rst, v, we, addr, be, data, rdy);
        model_cycle();
    endtask

    task automatic add(input bit v, input bit we, input logic [63:0] addr, input be_t be,
                       input logic [63:0] data, input bit rdy, input bit e_ready, input bit e_memv,
                       input bit e_memw, input logic [63:0] e_maddr, input bit e_v, input logic [63:0] e_data);
        vec_t r;
        r.v = v; r.we = we; r.addr = addr; r.be = be; r.data = data; r.rdy = rdy;
        r.e_ready = e_ready; r.e_memv = e_memv; r.e_memw = e_memw; r.e_maddr = e_maddr;
        r.e_v = e_v; r.e_data = e_data;
        tbl.push_back(r);
    endtask

    initial begin
        int       resp_cnt;
        bit       oor_pick;
        logic [63:0] a;

        for (int i = 0; i < els; i++) begin
            sram[i]      = 64'h0;
            model_mem[i] = 64'h0;
        end
        sram_q      = 64'h0;
        bus.v_i     = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = 64'h0;
        bus.be_i    = 8'h00;
        bus.data_i  = 64'h0;
        bus.ready_i = 1'b0;

        step(1'b1, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);

        //  v  we addr          be     data                    rdy   rdy memv memw maddr v  data
        add(1, 1, base + 64'h10, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1,    1, 1, 1, 64'd2, 0, 64'h0);
        add(1, 0, base + 64'h10, 8'h00, 64'h0,                 1,    1, 1, 0, 64'd2, 0, 64'h0);
        add(0, 0, base,          8'h00, 64'h0,                 1,    1, 0, 0, 64'd0, 1, 64'hDEADBEEF_CAFEF00D);
        add(1, 1, base + 64'h08, 8'h0F, 64'h11223344_55667788, 1,    1, 1, 1, 64'd1, 0, 64'h0);
        add(1, 0, base + 64'h00, 8'h00, 64'h0,                 0,    1, 1, 0, 64'd0, 0, 64'h0);
        add(1, 0, base + 64'h0F, 8'h00, 64'h0,                 0,    1, 1, 0, 64'd1, 1, 64'h0);
        add(1, 0, base + 64'h10, 8'h00, 64'h0,                 0,    0, 0, 0, 64'd0, 1, 64'h0);
        add(0, 0, base,          8'h00, 64'h0,                 1,    0, 0, 0, 64'd0, 1, 64'h0);
        add(0, 0, base,          8'h00, 64'h0,                 1,    1, 0, 0, 64'd0, 1, 64'h00000000_55667788);
        add(0, 0, base,          8'h00, 64'h0,                 1,    1, 0, 0, 64'd0, 0, 64'h0);
        add(1, 0, base + 64'h200, 8'h00, 64'h0,                1,    1, 0, 0, 64'd0, 0, 64'h0);
        add(0, 0, base,          8'h00, 64'h0,                 1,    1, 0, 0, 64'd0, 1, 64'h0);
        add(1, 1, base + 64'h200, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 1,   1, 0, 0, 64'd0, 0, 64'h0);
        add(1, 0, 64'h0FF8,      8'h00, 64'h0,                 1,    1, 0, 0, 64'd0, 0, 64'h0);
        add(1, 0, base + 64'h08, 8'h00, 64'h0,                 1,    1, 1, 0, 64'd1, 1, 64'h0);
        add(1, 0, base + 64'h00, 8'h00, 64'h0,                 1,    1, 1, 0, 64'd0, 1, 64'h00000000_55667788);
        add(0, 0, base,          8'h00, 64'h0,                 1,    1, 0, 0, 64'd0, 1, 64'h0);

        foreach (tbl[k]) begin
            drive(1'b0, tbl[k].v, tbl[k].we, tbl[k].addr, tbl[k].be, tbl[k].data, tbl[k].rdy);
            chk($sformatf("tbl%0d_ready", k), bus.ready_o, tbl[k].e_ready);
            chk($sformatf("tbl%0d_mem_v", k), bus.mem_v_o, tbl[k].e_memv);
            if (tbl[k].e_memv) begin
                chk($sformatf("tbl%0d_mem_w", k), bus.mem_w_o, tbl[k].e_memw);
                chk($sformatf("tbl%0d_mem_addr", k), bus.mem_addr_o, tbl[k].e_maddr);
            end
            chk($sformatf("tbl%0d_v", k), bus.v_o, tbl[k].e_v);
            if (tbl[k].e_v) chk($sformatf("tbl%0d_data", k), bus.data_o, tbl[k].e_data);
            model_cycle();
        end

        // Fill 16 words, then stream 16 reads with the consumer always ready.
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 1'b1, base + 64'(8 * i), 8'hFF, 64'h01010101_01010101 * 64'(i + 1), 1'b1);
        resp_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, i < 16, 1'b0, base + 64'(8 * i), 8'h00, 64'h0, 1'b1);
            if (bus.v_o) resp_cnt++;
            if (i > 0) chk("burst_v", bus.v_o, 64'd1);
            chk("burst_credits", 64'(dut.credits_r <= 2'd1), 64'd1);
            model_cycle();
        end
        chk("burst_count", 64'(resp_cnt), 64'd16);

        // Reset with two responses queued behind a stalled consumer.
        step(1'b0, 1'b1, 1'b0, base + 64'h18, 8'h00, 64'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, base + 64'h20, 8'h00, 64'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, base, 8'h00, 64'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, base, 8'h00, 64'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, base, 8'h00, 64'h0, 1'b1);
        chk("rst_v_dropped", bus.v_o, 64'd0);
        chk("rst_ready_low", bus.ready_o, 64'd0);
        model_cycle();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, base, 8'h00, 64'h0, 1'b1);

        // Completion arriving while reset is asserted must not surface afterwards.
        step(1'b0, 1'b1, 1'b0, base + 64'h08, 8'h00, 64'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, base, 8'h00, 64'h0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, base, 8'h00, 64'h0, 1'b1);

        // Random traffic, occasional out-of-range addresses and resets.
        for (int i = 0; i < 600; i++) begin
            oor_pick = ($urandom % 8) == 0;
            if (oor_pick) begin
                if ($urandom % 2 == 0) a = base + 64'h200 + 64'($urandom_range(0, 32'hFFF));
                else a = 64'($urandom_range(0, 32'hFFF));
            end else begin
                a = base + 64'($urandom_range(0, 511));
            end
            step(($urandom % 100) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0, a,
                 be_t'($urandom), {$urandom, $urandom}, ($urandom % 3) != 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, base, 8'h00, 64'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
